// File: rtl/weight_bank_pkg.sv
// Shared types and width helpers for the weight BRAM bank controller.
package weight_bank_pkg;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_GATHER = 2'd1,
        W_COMMIT = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_VALID = 2'd2
    } rd_state_e;

    localparam int TOTAL_W = 15;
    localparam int LAT_W   = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int step_w(input int banks);
        return clog2(banks + 1);
    endfunction

    function automatic int lane_w(input int banks);
        return clog2(banks + 1);
    endfunction

    function automatic int sel_w(input int banks);
        return (clog2(banks) < 1) ? 1 : clog2(banks);
    endfunction

endpackage

// File: rtl/weight_bank_ctrl_gather.sv
// Lane-fill registers for one commit: words land in lane order, mask marks filled lanes.
module weight_lane_gather
    import weight_bank_pkg::*;
#(
    parameter int WW     = 1280,
    parameter int BANKS  = 2,
    parameter int LANE_W = lane_w(BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [WW-1:0]         push_data,
    output logic [LANE_W-1:0]     lanes,
    output logic [BANKS-1:0]      mask,
    output logic [BANKS*WW-1:0]   wdata
);

    logic [LANE_W-1:0] lanes_q, lanes_d;
    logic [WW-1:0]     lane_q [BANKS];
    logic [WW-1:0]     lane_d [BANKS];

    always_comb begin
        lanes_d = lanes_q;
        lane_d  = lane_q;
        if (clr) begin
            lanes_d = '0;
        end else if (push) begin
            for (int b = 0; b < BANKS; b++)
                if (lanes_q == LANE_W'(b)) lane_d[b] = push_data;
            lanes_d = lanes_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= '0;
            for (int b = 0; b < BANKS; b++) lane_q[b] <= '0;
        end else begin
            lanes_q <= lanes_d;
            for (int b = 0; b < BANKS; b++) lane_q[b] <= lane_d[b];
        end
    end

    always_comb begin
        mask  = '0;
        wdata = '0;
        for (int b = 0; b < BANKS; b++) begin
            mask[b]           = int'(lanes_q) > b;
            wdata[b*WW +: WW] = lane_q[b];
        end
    end

    assign lanes = lanes_q;

endmodule

// File: rtl/weight_bank_ctrl.sv
// Weight BRAM bank controller: fills interleaved banks from the preload FIFO, serves MAC read bursts.
//   state    | meaning
//   W_IDLE   | no fill in progress
//   W_GATHER | popping FIFO words into commit lanes
//   W_COMMIT | writing filled lanes to banks at base+b
//   R_IDLE   | no read burst
//   R_WAIT   | banks enabled, latency down-counter running
//   R_VALID  | weight_out valid, waiting for a pointer step
module weight_bank_ctrl
    import weight_bank_pkg::*;
#(
    parameter  int MAC_NUM    = 256,
    parameter  int WEIGHT_W   = 5,
    parameter  int ADDR_W     = 12,
    parameter  int BANKS      = 2,
    parameter  int RD_LAT     = 2,
    parameter  int FIFO_CNT_W = 3,
    localparam int WW         = WEIGHT_W * MAC_NUM,
    localparam int STEP_W     = step_w(BANKS),
    localparam int SEL_W      = sel_w(BANKS),
    localparam int LANE_W     = lane_w(BANKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic                  transfer_start,
    input  logic [2:0]            cfg_kernel_size,
    input  logic [11:0]           cfg_out_ch,
    input  logic [FIFO_CNT_W-1:0] fifo_cnt,
    input  logic [WW-1:0]         fifo_data,
    output logic                  fifo_rd,
    output logic [BANKS*ADDR_W-1:0] bram_addr,
    output logic [BANKS-1:0]      bram_en,
    output logic [BANKS-1:0]      bram_we,
    output logic [BANKS*WW-1:0]   bram_wdata,
    input  logic [BANKS*WW-1:0]   bram_rdata,
    input  logic [STEP_W-1:0]     rd_step,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [WW-1:0]         weight_out,
    output logic                  weight_valid,
    output logic                  write_done,
    output logic                  busy
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    wr_state_e           w_state_q, w_state_d;
    rd_state_e           r_state_q, r_state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [TOTAL_W-1:0]  total_q, total_d, wcnt_q, wcnt_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                zero_done_q, zero_done_d;

    logic [LANE_W-1:0]   lanes;
    logic [BANKS-1:0]    commit_mask;
    logic [TOTAL_W-1:0]  total_in, remaining, lanes_ext, lanes_after;
    logic [STEP_W-1:0]   step_clamped;
    logic                wr_start, rd_start, pop, go_commit, commit_last, gather_clr;

    assign wr_start     = transfer_start && write_en;
    assign rd_start     = transfer_start && !write_en;
    assign total_in     = TOTAL_W'(cfg_out_ch) *
                          TOTAL_W'((cfg_kernel_size == 3'd0) ? 3'd1 : cfg_kernel_size);
    assign remaining    = total_q - wcnt_q;
    assign lanes_ext    = TOTAL_W'(lanes);
    assign pop          = (w_state_q == W_GATHER) && write_en && (fifo_cnt != '0) &&
                          (int'(lanes) < BANKS) && (lanes_ext < remaining);
    assign lanes_after  = lanes_ext + TOTAL_W'(pop);
    assign go_commit    = (lanes_after == TOTAL_W'(BANKS)) || (lanes_after == remaining) ||
                          ((fifo_cnt == '0) && (lanes != '0));
    assign commit_last  = (wcnt_q + lanes_ext) == total_q;
    assign step_clamped = (int'(rd_step) > BANKS) ? STEP_W'(BANKS) : rd_step;
    assign gather_clr   = (w_state_q == W_IDLE) || (w_state_q == W_COMMIT);

    weight_lane_gather #(
        .WW     (WW),
        .BANKS  (BANKS),
        .LANE_W (LANE_W)
    ) u_gather (
        .clk       (clk),
        .rst       (rst),
        .clr       (gather_clr),
        .push      (pop),
        .push_data (fifo_data),
        .lanes     (lanes),
        .mask      (commit_mask),
        .wdata     (bram_wdata)
    );

    always_comb begin
        w_state_d   = w_state_q;
        r_state_d   = r_state_q;
        base_d      = base_q;
        total_d     = total_q;
        wcnt_d      = wcnt_q;
        lat_d       = lat_q;
        zero_done_d = 1'b0;

        case (r_state_q)
            R_IDLE:  ;
            R_WAIT:  if (lat_q == '0) r_state_d = R_VALID;
                     else lat_d = lat_q - 1'b1;
            R_VALID: if (step_clamped != '0) begin
                         base_d    = base_q + ADDR_W'(step_clamped);
                         lat_d     = LAT_INIT;
                         r_state_d = R_WAIT;
                     end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_start) begin
            base_d    = '0;
            lat_d     = LAT_INIT;
            r_state_d = R_WAIT;
        end

        // Write case runs after the read case so a fill start wins the shared base.
        case (w_state_q)
            W_IDLE: if (wr_start) begin
                base_d  = '0;
                wcnt_d  = '0;
                total_d = total_in;
                if (total_in == '0) zero_done_d = 1'b1;
                else w_state_d = W_GATHER;
            end
            W_GATHER: begin
                if (!write_en) w_state_d = W_IDLE;
                else if (go_commit) w_state_d = W_COMMIT;
            end
            W_COMMIT: begin
                if (!write_en) begin
                    w_state_d = W_IDLE;
                end else begin
                    base_d    = base_q + ADDR_W'(lanes);
                    wcnt_d    = wcnt_q + lanes_ext;
                    w_state_d = commit_last ? W_IDLE : W_GATHER;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (wr_start) r_state_d = R_IDLE;
        if (rd_start) w_state_d = W_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            base_q      <= '0;
            total_q     <= '0;
            wcnt_q      <= '0;
            lat_q       <= '0;
            zero_done_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            base_q      <= base_d;
            total_q     <= total_d;
            wcnt_q      <= wcnt_d;
            lat_q       <= lat_d;
            zero_done_q <= zero_done_d;
        end
    end

    assign fifo_rd      = pop;
    assign busy         = (w_state_q != W_IDLE) || (r_state_q != R_IDLE);
    assign bram_we      = ((w_state_q == W_COMMIT) && write_en) ? commit_mask : '0;
    assign bram_en      = bram_we | {BANKS{r_state_q == R_WAIT}};
    assign write_done   = zero_done_q || ((w_state_q == W_COMMIT) && write_en && commit_last);
    assign weight_valid = (r_state_q == R_VALID);

    // Addresses are parked at zero while idle so the bank pins are quiet.
    always_comb begin
        bram_addr = '0;
        for (int b = 0; b < BANKS; b++)
            if (busy) bram_addr[b*ADDR_W +: ADDR_W] = base_q + ADDR_W'(b);
    end

    always_comb begin
        weight_out = bram_rdata[0 +: WW];
        for (int b = 1; b < BANKS; b++)
            if (rd_sel == SEL_W'(b)) weight_out = bram_rdata[b*WW +: WW];
    end

endmodule

// File: tb/tb_weight_bank_ctrl.sv
// Self-checking bench for weight_bank_ctrl: fill scoreboard, read timing model, reset cases.
module tb_weight_bank_ctrl;
    import weight_bank_pkg::*;

    localparam int MAC_NUM    = 4;
    localparam int WEIGHT_W   = 5;
    localparam int ADDR_W     = 12;
    localparam int BANKS      = 2;
    localparam int RD_LAT     = 3;
    localparam int FIFO_CNT_W = 3;
    localparam int WW         = MAC_NUM * WEIGHT_W;
    localparam int STEP_W     = step_w(BANKS);
    localparam int SEL_W      = sel_w(BANKS);
    localparam int AMASK      = (1 << ADDR_W) - 1;
    localparam int NO_GAP     = 1000000;

    logic clk = 1'b0;
    logic rst, write_en, transfer_start;
    logic [2:0] cfg_kernel_size;
    logic [11:0] cfg_out_ch;
    logic [FIFO_CNT_W-1:0] fifo_cnt;
    logic [WW-1:0] fifo_data;
    logic fifo_rd;
    logic [BANKS*ADDR_W-1:0] bram_addr;
    logic [BANKS-1:0] bram_en, bram_we;
    logic [BANKS*WW-1:0] bram_wdata, bram_rdata;
    logic [STEP_W-1:0] rd_step;
    logic [SEL_W-1:0] rd_sel;
    logic [WW-1:0] weight_out;
    logic weight_valid, write_done, busy;

    weight_bank_ctrl #(
        .MAC_NUM(MAC_NUM), .WEIGHT_W(WEIGHT_W), .ADDR_W(ADDR_W),
        .BANKS(BANKS), .RD_LAT(RD_LAT), .FIFO_CNT_W(FIFO_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .transfer_start(transfer_start),
        .cfg_kernel_size(cfg_kernel_size), .cfg_out_ch(cfg_out_ch),
        .fifo_cnt(fifo_cnt), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .rd_step(rd_step), .rd_sel(rd_sel), .weight_out(weight_out),
        .weight_valid(weight_valid), .write_done(write_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [WW-1:0] fifo_q[$];
    logic [WW-1:0] popped[$];
    int commit_c[$];
    int commit_n[$];
    int wr_idx, n_pops, n_done, done_c, first_pop_c;
    bit saw_wrap;

    task automatic observe_fill(input int c, input int total);
        int n;
        logic [WW-1:0] exp_d;
        if (fifo_rd) begin
            check("pop_nonempty", fifo_cnt != '0, 1);
            if (fifo_q.size() > 0) popped.push_back(fifo_q.pop_front());
            if (first_pop_c < 0) first_pop_c = c;
            n_pops++;
        end
        if (bram_we != '0) begin
            n = $countones(bram_we);
            check("we_prefix", bram_we, (1 << n) - 1);
            check("en_covers_we", bram_en & bram_we, bram_we);
            for (int b = 0; b < n; b++) begin
                exp_d = (wr_idx + b < popped.size()) ? popped[wr_idx + b] : 'x;
                check("wr_addr", bram_addr[b*ADDR_W +: ADDR_W], (wr_idx + b) & AMASK);
                check("wr_data", bram_wdata[b*WW +: WW], exp_d);
            end
            if (n == 2 && bram_addr[0 +: ADDR_W] == ADDR_W'(AMASK) && bram_addr[ADDR_W +: ADDR_W] == '0)
                saw_wrap = 1'b1;
            commit_c.push_back(c);
            commit_n.push_back(n);
            wr_idx += n;
        end
        if (write_done) begin
            n_done++;
            done_c = c;
            check("done_all_written", wr_idx, total);
        end
    endtask

    task automatic run_fill(input int ks, input int oc, input int gap_lo, input int gap_hi,
                            input int pct, input int max_cyc);
        int total;
        bit avail;
        total = oc * ((ks == 0) ? 1 : ks);
        fifo_q.delete(); popped.delete(); commit_c.delete(); commit_n.delete();
        wr_idx = 0; n_pops = 0; n_done = 0; done_c = -1; first_pop_c = -1; saw_wrap = 1'b0;
        for (int i = 0; i < total; i++) fifo_q.push_back(WW'($urandom));
        cfg_kernel_size = 3'(ks);
        cfg_out_ch      = 12'(oc);
        write_en        = 1'b1;
        for (int c = 0; c <= max_cyc; c++) begin
            avail          = (c < gap_lo || c > gap_hi) && ($urandom_range(99) < pct);
            transfer_start = (c == 0);
            fifo_cnt       = avail ? FIFO_CNT_W'((fifo_q.size() > 7) ? 7 : fifo_q.size()) : '0;
            fifo_data      = (fifo_q.size() > 0) ? fifo_q[0] : '0;
            #2;
            observe_fill(c, total);
            @(posedge clk); #1;
            if (n_done != 0) break;
        end
        transfer_start = 1'b0;
        fifo_cnt       = '0;
        check("fill_done_once", n_done, 1);
        check("fill_pops", n_pops, total);
        check("fill_written", wr_idx, total);
    endtask

    initial begin
        int rbase, nv;
        bit vexp;
        rst = 1'b1; write_en = 1'b0; transfer_start = 1'b0;
        cfg_kernel_size = 3'd1; cfg_out_ch = '0; fifo_cnt = '0; fifo_data = '0;
        bram_rdata = '0; rd_step = '0; rd_sel = '0;
        #3;
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_bram_we", bram_we, 0);
        check("rst_bram_addr", bram_addr, 0);
        check("rst_wdata", bram_wdata, 0);
        check("rst_valid", weight_valid, 0);
        check("rst_done", write_done, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Full FIFO: one BANKS-wide commit every BANKS+1 cycles.
        run_fill(1, 4, NO_GAP, NO_GAP, 100, 40);
        check("A_first_pop", first_pop_c, 1);
        check("A_commits", commit_c.size(), 2);
        check("A_commit0_c", (commit_c.size() > 0) ? commit_c[0] : -1, BANKS + 1);
        check("A_commit1_c", (commit_c.size() > 1) ? commit_c[1] : -1, 2 * (BANKS + 1));
        check("A_done_c", done_c, 2 * (BANKS + 1));

        // One word then empty FIFO: partial commit of 1, then 2.
        run_fill(3, 1, 2, 6, 100, 40);
        check("B_commits", commit_c.size(), 2);
        check("B_commit0_c", (commit_c.size() > 0) ? commit_c[0] : -1, 3);
        check("B_commit0_n", (commit_n.size() > 0) ? commit_n[0] : -1, 1);
        check("B_commit1_c", (commit_c.size() > 1) ? commit_c[1] : -1, 9);
        check("B_commit1_n", (commit_n.size() > 1) ? commit_n[1] : -1, 2);
        check("B_done_c", done_c, 9);

        run_fill(5, 0, NO_GAP, NO_GAP, 100, 10);
        check("C_done_c", done_c, 1);
        check("C_busy", busy, 0);

        run_fill(0, 5, NO_GAP, NO_GAP, 100, 40);
        for (int i = 0; i < 4; i++)
            run_fill($urandom_range(7), $urandom_range(1, 20), NO_GAP, NO_GAP, 60, 600);

        // Abort mid-gather.
        cfg_kernel_size = 3'd1; cfg_out_ch = 12'd10; fifo_cnt = 3'd7;
        for (int c = 0; c <= 12; c++) begin
            write_en       = (c < 2);
            transfer_start = (c == 0);
            fifo_data      = WW'($urandom);
            #2;
            if (c == 1) check("D_pop_c1", fifo_rd, 1);
            if (c >= 3) check("D_no_pop", fifo_rd, 0);
            if (c >= 2) check("D_no_we", bram_we, 0);
            check("D_no_done", write_done, 0);
            @(posedge clk); #1;
        end
        transfer_start = 1'b0; fifo_cnt = '0;
        check("D_idle", busy, 0);

        // Read bursts against a cycle model of valid windows and the base pointer.
        write_en = 1'b0;
        rbase = 0; nv = -1;
        for (int c = 0; c < 200; c++) begin
            transfer_start = (c == 0) || (c == 150);
            if (c == 5) rd_step = STEP_W'(2);
            else if (c > 12 && $urandom_range(2) == 0) rd_step = STEP_W'($urandom_range(3));
            else rd_step = '0;
            rd_sel     = SEL_W'($urandom_range(BANKS - 1));
            bram_rdata = (BANKS*WW)'({$urandom, $urandom});
            #2;
            vexp = (nv >= 0) && (c >= nv);
            check("rd_valid", weight_valid, vexp);
            check("rd_wout", weight_out, bram_rdata[int'(rd_sel)*WW +: WW]);
            if (nv >= 0) begin
                check("rd_addr0", bram_addr[0 +: ADDR_W], rbase & AMASK);
                check("rd_addr1", bram_addr[ADDR_W +: ADDR_W], (rbase + 1) & AMASK);
                if (!vexp) check("rd_en_all", bram_en, (1 << BANKS) - 1);
            end
            if (c == 6) check("E_addr_after_step", bram_addr[0 +: ADDR_W], 2);
            if (c == 8) check("E_valid_low", weight_valid, 0);
            if (c == 9) check("E_valid_back", weight_valid, 1);
            if (transfer_start) begin
                rbase = 0; nv = c + RD_LAT + 1;
            end else if (vexp && rd_step != '0) begin
                rbase = (rbase + ((int'(rd_step) > BANKS) ? BANKS : int'(rd_step))) & AMASK;
                nv = c + RD_LAT + 1;
            end
            @(posedge clk); #1;
        end
        transfer_start = 1'b0; rd_step = '0;

        // Fill start during a read burst idles the read side.
        cfg_out_ch = '0;
        write_en = 1'b1; transfer_start = 1'b1;
        #2;
        check("G_busy_before", busy, 1);
        @(posedge clk); #1;
        transfer_start = 1'b0;
        #2;
        check("G_done", write_done, 1);
        check("G_busy", busy, 0);
        for (int c = 0; c < RD_LAT + 2; c++) begin
            check("G_no_valid", weight_valid, 0);
            @(posedge clk); #1;
        end

        // Odd base after a partial commit drives a pair commit across the wrap.
        run_fill(2, 2049, 2, 3, 100, 7000);
        check("F_wrap_seen", saw_wrap, 1);

        // Async reset mid-fill.
        cfg_kernel_size = 3'd1; cfg_out_ch = 12'd10; fifo_cnt = 3'd7; write_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            transfer_start = (c == 0);
            fifo_data = WW'($urandom);
            @(posedge clk); #1;
        end
        transfer_start = 1'b0;
        #2;
        check("H_pre_rst_we", bram_we, (1 << BANKS) - 1);
        rst = 1'b1;
        #1;
        check("H_fifo_rd", fifo_rd, 0);
        check("H_we", bram_we, 0);
        check("H_en", bram_en, 0);
        check("H_addr", bram_addr, 0);
        check("H_wdata", bram_wdata, 0);
        check("H_done", write_done, 0);
        check("H_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("H_idle_after", busy, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
